// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Purpose : Shared types, defaults and helpers for the hazard scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  // Default register specifier width (rd/rs/rt).
  localparam int REG_ADDR_W_DEF = 6;

  // Widest counter the saturating helper supports.
  localparam int CNT_W_MAX = 32;

  // Scoreboard entry shape at the default register width. The top module
  // re-declares the same shape at its own REG_ADDR_W.
  typedef struct packed {
    logic                      v;
    logic [REG_ADDR_W_DEF-1:0] rd;
  } sb_entry_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [CNT_W_MAX-1:0] sat_inc(
    input logic [CNT_W_MAX-1:0] val,
    input logic [CNT_W_MAX-1:0] max_val
  );
    return (val == max_val) ? val : (val + 32'd1);
  endfunction

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/hazard_scoreboard_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Purpose : Saturating event counter; holds at all-ones, never wraps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // All-ones at CNT_W, zero-extended to the helper width.
  localparam logic [CNT_W_MAX-1:0] MAX_VAL = CNT_W_MAX'({CNT_W{1'b1}});

  // Count one per cycle with inc high, clamped at MAX_VAL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc) begin
      count <= CNT_W'(sat_inc(CNT_W_MAX'(count), MAX_VAL));
    end
  end

endmodule : sat_counter

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module  : hazard_scoreboard
// Purpose : RAW interlock and branch-flush unit sitting beside the ID stage.
//           Tracks destination registers of in-flight instructions in a
//           DEPTH-entry shift scoreboard (entry 0 youngest, DEPTH-1 is WB).
//           Optional build macro: HAZARD_SCOREBOARD_WB_BYPASS_EN - excludes
//           the WB entry from the hazard compare (write-through regfile).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_wrt,
  input  logic                  wb_branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic                  issue,
  output logic [DEPTH-1:0]      pending_mask,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  // Entry shape at this instance's register width.
  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
  } entry_t;

  // Number of entries (counted from the youngest) that take part in the
  // hazard compare. With a write-through register file the WB entry's value
  // is already visible to ID, so it need not cause a stall.
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
  localparam int CMP_N = DEPTH - 1;
`else
  localparam int CMP_N = DEPTH;
`endif

  entry_t sb [DEPTH];
  logic   hit;

  // RAW hazard: any compared, valid entry whose rd matches a source that the
  // ID instruction actually reads. Register 0 is an ordinary register here.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < CMP_N; i++) begin
      if (sb[i].v &&
          ((id_rs_used && (sb[i].rd == id_rs)) ||
           (id_rt_used && (sb[i].rd == id_rt)))) begin
        hit = 1'b1;
      end
    end
  end

  // A taken branch in WB overrides any hazard: the ID instruction is being
  // squashed anyway, so stalling it would only waste a cycle.
  always_comb begin
    flush = wb_branch_taken;
    stall = id_valid & hit & ~wb_branch_taken;
    issue = id_valid & ~stall & ~flush;
  end

  // Scoreboard shift. Stalls do not freeze it: bubbles keep shifting in so a
  // hazard always clears within DEPTH cycles. On a flush every younger entry
  // is squashed; the branch itself sits in the last entry and retires on
  // this edge, so its link write still completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb[i] <= '0;
      end
    end else begin
      sb[0].v  <= issue & id_reg_wrt;
      sb[0].rd <= id_rd;
      for (int i = 1; i < DEPTH; i++) begin
        sb[i].v  <= sb[i-1].v & ~flush;
        sb[i].rd <= sb[i-1].rd;
      end
    end
  end

  // Expose entry valid bits; bit 0 is the youngest.
  for (genvar g = 0; g < DEPTH; g++) begin : g_mask
    assign pending_mask[g] = sb[g].v;
  end

  // Performance counter: cycles spent stalled.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (stall),
    .count   (stall_cycles)
  );

  // Performance counter: flush events.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (flush),
    .count   (flush_count)
  );

endmodule : hazard_scoreboard

`default_nettype wire
